// File: rtl/instruction_loader.sv
// Byte-serial instruction loader: accepts 32-bit words over valid/ready and writes them
// big-endian, one byte per cycle, into the byte-wide instruction memory write port.
module instruction_loader #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [31:0]           inInstruction,
  input  logic                  inLast,
  output logic                  memWriteEnable,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic [7:0]            memWriteData,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [ADDR_WIDTH-2:0] wordCount
);

  localparam int unsigned CntW = ADDR_WIDTH - 1;
  localparam logic [ADDR_WIDTH-1:0] BaseAddr = ADDR_WIDTH'(BASE_ADDR);
  // Base address of the final word slot (depth - 4); reaching it without inLast overflows.
  localparam logic [ADDR_WIDTH-1:0] LastSlot = {ADDR_WIDTH{1'b1}} - ADDR_WIDTH'(3);

  typedef enum logic [1:0] {StIdle, StLoad, StWrite, StDone} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [1:0]            idx_q, idx_d;
  logic [31:0]           word_q, word_d;
  logic                  last_q, last_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;

  // Registered outputs, computed from the next state so they line up with it.
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            data_q, data_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    word_d  = word_q;
    last_d  = last_q;
    count_d = count_q;
    done_d  = done_q;
    ovf_d   = ovf_q;

    if (start) begin
      state_d = StLoad;
      ptr_d   = BaseAddr;
      idx_d   = 2'd0;
      count_d = '0;
      done_d  = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
        end
        StLoad: begin
          if (inValid && ready_q) begin
            word_d  = inInstruction;
            last_d  = inLast;
            idx_d   = 2'd0;
            state_d = StWrite;
          end
        end
        StWrite: begin
          if (idx_q == 2'd3) begin
            idx_d   = 2'd0;
            count_d = count_q + CntW'(1);
            if (last_q) begin
              state_d = StDone;
              done_d  = 1'b1;
            end else if (ptr_q == LastSlot) begin
              state_d = StDone;
              done_d  = 1'b1;
              ovf_d   = 1'b1;
            end else begin
              ptr_d   = ptr_q + ADDR_WIDTH'(4);
              state_d = StLoad;
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
        StDone: begin
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    ready_d = (state_d == StLoad);
    busy_d  = (state_d == StLoad) || (state_d == StWrite);
    we_d    = (state_d == StWrite);
    addr_d  = '0;
    data_d  = '0;
    if (we_d) begin
      addr_d = ptr_d + {{(ADDR_WIDTH-2){1'b0}}, idx_d};
      unique case (idx_d)
        2'd0: data_d = word_d[31:24];
        2'd1: data_d = word_d[23:16];
        2'd2: data_d = word_d[15:8];
        2'd3: data_d = word_d[7:0];
        default: data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= BaseAddr;
      idx_q   <= 2'd0;
      word_q  <= '0;
      last_q  <= 1'b0;
      count_q <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      last_q  <= last_d;
      count_q <= count_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign inReady        = ready_q;
  assign busy           = busy_q;
  assign memWriteEnable = we_q;
  assign memAddress     = addr_q;
  assign memWriteData   = data_q;
  assign done           = done_q;
  assign overflow       = ovf_q;
  assign wordCount      = count_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: byte writes are checked against a scoreboard of
// expected (address, data) pairs pushed when each word is offered.
module tb_instruction_loader;

  typedef struct packed {
    logic [5:0] a;
    logic [7:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start0 = 1'b0;
  logic        start8 = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [31:0] in_instr = '0;

  logic       rdy0, we0, busy0, done0, ovf0;
  logic [5:0] addr0;
  logic [7:0] data0;
  logic [4:0] cnt0;
  logic       rdy8, we8, busy8, done8, ovf8;
  logic [5:0] addr8;
  logic [7:0] data8;
  logic [4:0] cnt8;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  wr_t        q0[$];
  wr_t        q8[$];
  logic [5:0] ptr0 = 6'd0;
  logic [5:0] ptr8 = 6'd8;
  int         wc0 = 0;
  int         wc8 = 0;

  instruction_loader #(.ADDR_WIDTH(6), .BASE_ADDR(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .inValid(in_valid), .inReady(rdy0),
    .inInstruction(in_instr), .inLast(in_last), .memWriteEnable(we0), .memAddress(addr0),
    .memWriteData(data0), .busy(busy0), .done(done0), .overflow(ovf0), .wordCount(cnt0)
  );

  instruction_loader #(.ADDR_WIDTH(6), .BASE_ADDR(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .inValid(in_valid), .inReady(rdy8),
    .inInstruction(in_instr), .inLast(in_last), .memWriteEnable(we8), .memAddress(addr8),
    .memWriteData(data8), .busy(busy8), .done(done8), .overflow(ovf8), .wordCount(cnt8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic wr_t mk(input logic [5:0] a, input logic [7:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    return e;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard: every strobed byte must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (we0) begin
      if (q0.size() == 0) chk("dut0 unexpected write", 64'(we0), 64'(0));
      else begin
        e = q0.pop_front();
        chk("dut0 write addr", 64'(addr0), 64'(e.a));
        chk("dut0 write data", 64'(data0), 64'(e.d));
      end
    end
    if (we8) begin
      if (q8.size() == 0) chk("dut8 unexpected write", 64'(we8), 64'(0));
      else begin
        e = q8.pop_front();
        chk("dut8 write addr", 64'(addr8), 64'(e.a));
        chk("dut8 write data", 64'(data8), 64'(e.d));
      end
    end
  end

  task automatic do_start(input bit d);
    if (d) start8 = 1'b1;
    else start0 = 1'b1;
    step(1);
    start0 = 1'b0;
    start8 = 1'b0;
    if (d) begin
      ptr8 = 6'd8;
      wc8  = 0;
    end else begin
      ptr0 = 6'd0;
      wc0  = 0;
    end
  endtask

  task automatic send(input bit d, input logic [31:0] w, input logic last);
    int         waited = 0;
    logic [5:0] base;
    logic       full;
    logic [7:0] b;
    in_instr = w;
    in_last  = last;
    in_valid = 1'b1;
    while (!(d ? rdy8 : rdy0) && waited < 20) begin
      step(1);
      waited++;
    end
    chk("send ready", 64'(d ? rdy8 : rdy0), 64'(1));
    if (!(d ? rdy8 : rdy0)) begin
      in_valid = 1'b0;
      return;
    end
    base = d ? ptr8 : ptr0;
    for (int k = 0; k < 4; k++) begin
      b = w[31-8*k -: 8];
      if (d) q8.push_back(mk(base + 6'(k), b));
      else q0.push_back(mk(base + 6'(k), b));
    end
    step(1);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("byte strobe", 64'(d ? we8 : we0), 64'(1));
      chk("busy in write", 64'(d ? busy8 : busy0), 64'(1));
      step(1);
    end
    full = last || (base == 6'd60);
    if (d) wc8++;
    else wc0++;
    chk("strobe off after word", 64'(d ? we8 : we0), 64'(0));
    chk("ready after word", 64'(d ? rdy8 : rdy0), 64'(!full));
    chk("done after word", 64'(d ? done8 : done0), 64'(full));
    chk("overflow after word", 64'(d ? ovf8 : ovf0), 64'(!last && base == 6'd60));
    chk("wordCount after word", 64'(d ? cnt8 : cnt0), 64'(d ? wc8 : wc0));
    if (!full) begin
      if (d) ptr8 = base + 6'd4;
      else ptr0 = base + 6'd4;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " inReady"}, 64'(rdy0), 64'(0));
    chk({tag, " memWriteEnable"}, 64'(we0), 64'(0));
    chk({tag, " memAddress"}, 64'(addr0), 64'(0));
    chk({tag, " memWriteData"}, 64'(data0), 64'(0));
    chk({tag, " busy"}, 64'(busy0), 64'(0));
    chk({tag, " done"}, 64'(done0), 64'(0));
    chk({tag, " overflow"}, 64'(ovf0), 64'(0));
    chk({tag, " wordCount"}, 64'(cnt0), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and idle behaviour
    step(3);
    chk_all_zero("reset");
    rst_n = 1'b1;
    step(3);
    chk("idle ready", 64'(rdy0), 64'(0));
    chk("idle busy", 64'(busy0), 64'(0));

    // Two-word load
    do_start(0);
    chk("ready after start", 64'(rdy0), 64'(1));
    chk("busy after start", 64'(busy0), 64'(1));
    send(0, 32'hF842_802A, 1'b0);
    send(0, 32'hCB03_804B, 1'b1);
    chk("two-word busy", 64'(busy0), 64'(0));

    // Restart from DONE, then stall with inValid low
    do_start(0);
    chk("restart done cleared", 64'(done0), 64'(0));
    chk("restart count cleared", 64'(cnt0), 64'(0));
    for (int i = 0; i < 10; i++) begin
      chk("stall ready", 64'(rdy0), 64'(1));
      chk("stall no write", 64'(we0), 64'(0));
      step(1);
    end
    chk("stall wordCount", 64'(cnt0), 64'(0));
    send(0, 32'h8B03_008C, 1'b1);

    // start and inValid on the same edge: start wins, then fill memory to overflow
    do_start(0);
    in_instr = 32'h1234_5678;
    in_valid = 1'b1;
    start0   = 1'b1;
    step(1);
    start0   = 1'b0;
    in_valid = 1'b0;
    chk("start beats valid: no write", 64'(we0), 64'(0));
    chk("start beats valid: ready", 64'(rdy0), 64'(1));
    for (int i = 0; i < 16; i++) send(0, 32'hA5A5_0000 ^ (32'(i) * 32'h0101_1337), 1'b0);
    chk("overflow flag", 64'(ovf0), 64'(1));
    chk("overflow wordCount", 64'(cnt0), 64'(16));
    in_instr = 32'hDEAD_BEEF;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("17th word refused", 64'(rdy0), 64'(0));
      step(1);
    end
    in_valid = 1'b0;
    chk("overflow count held", 64'(cnt0), 64'(16));

    // Abort during byte index 1 of the word at ptr=4
    do_start(0);
    send(0, 32'h8B03_0001, 1'b0);
    in_instr = 32'hD280_0123;
    in_last  = 1'b0;
    in_valid = 1'b1;
    chk("abort word ready", 64'(rdy0), 64'(1));
    q0.push_back(mk(6'd4, 8'hD2));
    q0.push_back(mk(6'd5, 8'h80));
    step(1);
    in_valid = 1'b0;
    step(1);
    chk("abort at index 1", 64'(addr0), 64'(5));
    start0 = 1'b1;
    step(1);
    start0 = 1'b0;
    ptr0   = 6'd0;
    wc0    = 0;
    chk("abort no write", 64'(we0), 64'(0));
    chk("abort ready", 64'(rdy0), 64'(1));
    chk("abort wordCount", 64'(cnt0), 64'(0));
    send(0, 32'h9100_0421, 1'b1);

    // Non-zero base address build
    do_start(1);
    chk("base8 ready", 64'(rdy8), 64'(1));
    send(1, 32'hF844_802D, 1'b1);
    chk("base8 wordCount", 64'(cnt8), 64'(1));

    // Asynchronous reset in the middle of a word
    do_start(0);
    in_instr = 32'hFFFF_FFFF;
    in_last  = 1'b1;
    in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk_all_zero("async reset");
    step(2);
    #1 rst_n = 1'b1;
    step(3);
    chk("post-reset idle ready", 64'(rdy0), 64'(0));
    chk("post-reset idle write", 64'(we0), 64'(0));
    chk("post-reset busy", 64'(busy0), 64'(0));

    chk("dut0 writes drained", 64'(q0.size()), 64'(0));
    chk("dut8 writes drained", 64'(q8.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
